// File: rtl/coincidence_pkg.sv
// Shared control-section definitions: coincidence FSM state encoding, the
// default minor-cycle length and a counter-width helper.
package coincidence_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALIGN    = 3'd1,
    ST_COMPARE  = 3'd2,
    ST_TRANSFER = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int MINOR_CYCLE_DEF = 18;

  // Bits needed to hold the values 0..n-1 (never less than one).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coincidence_unit_digit_counter.sv
// d1-synchronised digit index generator (0..MINOR_CYCLE-1) for serial stages.
module digit_counter
  import coincidence_pkg::*;
#(
  parameter int MINOR_CYCLE = MINOR_CYCLE_DEF,
  parameter int IDX_W       = cnt_width(MINOR_CYCLE)
) (
  input  logic             clk,
  input  logic             reset_neg,
  input  logic             d1,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MINOR_CYCLE - 1);

  logic [IDX_W-1:0] cnt_r;

  // d1 names digit 0 in the very clock it is seen, so the index is muxed
  // rather than waiting for the register to catch up.
  always_comb begin
    idx = d1 ? {IDX_W{1'b0}} : cnt_r;
  end

  // Index for the following clock: wrap after the last digit time.
  always_ff @(posedge clk) begin
    if (!reset_neg) begin
      cnt_r <= {IDX_W{1'b0}};
    end else if (idx == LAST_IDX) begin
      cnt_r <= {IDX_W{1'b0}};
    end else begin
      cnt_r <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/coincidence_unit.sv
// Serial address-coincidence stage: matches the tank counter stream against a
// latched word address and opens a one- or two-minor-cycle transfer gate.
module coincidence_unit
  import coincidence_pkg::*;
#(
  parameter int MINOR_CYCLE = MINOR_CYCLE_DEF,
  parameter int ADDR_BITS   = 5,
  parameter int TIMEOUT     = 40
) (
  input  logic                 clk,
  input  logic                 reset_neg,
  input  logic                 cntr,
  input  logic                 d1,
  input  logic                 req,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 long_word,
  output logic                 busy,
  output logic                 gate,
  output logic                 done,
  output logic                 err
);

  localparam int IDX_W  = cnt_width(MINOR_CYCLE);
  localparam int SRCH_W = cnt_width(TIMEOUT + 1);
  localparam int XFER_W = cnt_width(2 * MINOR_CYCLE);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(MINOR_CYCLE - 1);
  localparam logic [SRCH_W-1:0] SRCH_LAST  = SRCH_W'(TIMEOUT - 1);
  localparam logic [XFER_W-1:0] XFER_SHORT = XFER_W'(MINOR_CYCLE - 1);
  localparam logic [XFER_W-1:0] XFER_LONG  = XFER_W'(2 * MINOR_CYCLE - 1);

  state_e                state_r;
  logic [IDX_W-1:0]      idx_s;
  logic [ADDR_BITS-1:0]  addr_q_r;
  logic                  long_q_r;
  logic                  mismatch_r;
  logic [SRCH_W-1:0]     search_r;
  logic [XFER_W-1:0]     xfer_r;
  logic                  ref_bit_s;
  logic                  in_field_s;
  logic                  bit_miss_s;
  logic                  mism_s;
  logic                  xfer_last_s;

  digit_counter #(
    .MINOR_CYCLE (MINOR_CYCLE),
    .IDX_W       (IDX_W)
  ) u_digit_counter (
    .clk       (clk),
    .reset_neg (reset_neg),
    .d1        (d1),
    .idx       (idx_s)
  );

  // Address bit under comparison this digit time; digits past the field are ignored.
  always_comb begin
    ref_bit_s  = 1'b0;
    in_field_s = 1'b0;
    for (int i = 0; i < ADDR_BITS; i++) begin
      ref_bit_s  = ref_bit_s  | (addr_q_r[i] & (idx_s == IDX_W'(i)));
      in_field_s = in_field_s | (idx_s == IDX_W'(i));
    end
    bit_miss_s  = in_field_s & (cntr ^ ref_bit_s);
    mism_s      = mismatch_r | bit_miss_s;
    xfer_last_s = (xfer_r == (long_q_r ? XFER_LONG : XFER_SHORT));
  end

  // Coincidence FSM with registered status and gate outputs.
  always_ff @(posedge clk) begin
    if (!reset_neg) begin
      state_r    <= ST_IDLE;
      addr_q_r   <= {ADDR_BITS{1'b0}};
      long_q_r   <= 1'b0;
      mismatch_r <= 1'b0;
      search_r   <= {SRCH_W{1'b0}};
      xfer_r     <= {XFER_W{1'b0}};
      busy       <= 1'b0;
      gate       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            addr_q_r <= addr;
            long_q_r <= long_word;
            busy     <= 1'b1;
            state_r  <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          // Bit 0 is compared on the aligning d1 clock itself.
          if (d1) begin
            mismatch_r <= bit_miss_s;
            search_r   <= {SRCH_W{1'b0}};
            state_r    <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (idx_s == LAST_IDX) begin
            mismatch_r <= 1'b0;
            if (!mism_s) begin
              gate    <= 1'b1;
              xfer_r  <= {XFER_W{1'b0}};
              state_r <= ST_TRANSFER;
            end else if (search_r == SRCH_LAST) begin
              search_r <= search_r + SRCH_W'(1);
              err      <= 1'b1;
              busy     <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              search_r <= search_r + SRCH_W'(1);
            end
          end else begin
            mismatch_r <= mism_s;
          end
        end
        ST_TRANSFER: begin
          // Fixed-length window counted locally, independent of d1.
          if (xfer_last_s) begin
            gate    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            xfer_r <= xfer_r + XFER_W'(1);
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          gate    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coincidence_unit.sv
// Self-checking bench for coincidence_unit: timestamp-based reference model,
// per-cycle output compare, directed scenarios and randomized traffic.
module tb_coincidence_unit;

  localparam int MC = 18;
  localparam int AB = 5;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          reset_neg = 1'b0;
  logic          cntr = 1'b0;
  logic          d1 = 1'b0;
  logic          req = 1'b0;
  logic [AB-1:0] addr = '0;
  logic          long_word = 1'b0;
  logic          busy, gate, done, err;

  coincidence_unit #(.MINOR_CYCLE(MC), .ADDR_BITS(AB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_neg(reset_neg), .cntr(cntr), .d1(d1), .req(req),
    .addr(addr), .long_word(long_word), .busy(busy), .gate(gate),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;      // index of the current clock interval
  int printed = 0;

  // tank counter stimulus: pos presented LSB first, one minor cycle per word
  int          sp = 0;
  logic [17:0] pos = '0;
  int          cmode = 1;   // 0 = counting, 1 = frozen

  // ---------------- reference model ----------------
  int            m_mode = 0;  // 0 idle, 1 wait d1, 2 searching, 3 gate open, 4 finishing
  int            m_last_d1 = 0;
  int            m_tries = 0;
  int            m_gate_end = 0;
  logic [AB-1:0] m_addr = '0;
  logic          m_long = 1'b0;
  logic          m_bad = 1'b0;
  logic          e_busy = 1'b0, e_gate = 1'b0, e_done = 1'b0, e_err = 1'b0;

  always @(posedge clk) begin
    int idx;
    if (!reset_neg) begin
      m_mode = 0; m_addr = '0; m_long = 1'b0; m_bad = 1'b0; m_tries = 0;
      e_busy = 1'b0; e_gate = 1'b0; e_done = 1'b0; e_err = 1'b0;
      m_last_d1 = cyc + 1;
    end else begin
      if (d1) m_last_d1 = cyc;
      idx = (cyc - m_last_d1) % MC;
      e_done = 1'b0;
      e_err  = 1'b0;
      case (m_mode)
        0: if (req) begin
             m_addr = addr; m_long = long_word; e_busy = 1'b1; m_mode = 1;
           end
        1: if (d1) begin
             m_mode = 2; m_tries = 0; m_bad = (cntr != m_addr[0]);
           end
        2: begin
             if (idx < AB && cntr != m_addr[idx]) m_bad = 1'b1;
             if (idx == MC - 1) begin
               if (!m_bad) begin
                 m_mode = 3; e_gate = 1'b1;
                 m_gate_end = cyc + (m_long ? 2 * MC : MC);
               end else begin
                 m_bad = 1'b0;
                 m_tries++;
                 if (m_tries == TO) begin
                   e_err = 1'b1; e_busy = 1'b0; m_mode = 0;
                 end
               end
             end
           end
        3: if (cyc == m_gate_end) begin
             e_gate = 1'b0; e_done = 1'b1; m_mode = 4;
           end
        default: begin
             e_busy = 1'b0; m_mode = 0;
           end
      endcase
    end
    cyc = cyc + 1;
  end

  // ---------------- per-cycle compare and event monitors ----------------
  int   gate_rise = -1, gate_len = 0, done_cnt = 0, err_cnt = 0, err_rise = -1;
  logic gate_prev = 1'b0;

  always @(negedge clk) begin
    checks++;
    if ({busy, gate, done, err} !== {e_busy, e_gate, e_done, e_err}) begin
      errors++;
      if (printed < 20) begin
        printed++;
        $display("FAIL outputs @cycle %0d: busy/gate/done/err got %b required %b",
                 cyc, {busy, gate, done, err}, {e_busy, e_gate, e_done, e_err});
      end
    end
    if (gate === 1'b1 && gate_prev !== 1'b1) begin
      gate_rise = cyc;
      gate_len  = 0;
    end
    if (gate === 1'b1) gate_len++;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) begin
      err_cnt++;
      err_rise = cyc;
    end
    gate_prev = gate;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Drive one clock interval of stimulus.
  task automatic tick(input logic r, input logic rq, input logic [AB-1:0] a,
                      input logic lw, input bit fd1);
    @(posedge clk);
    #2;
    reset_neg = r; req = rq; addr = a; long_word = lw;
    if (fd1) sp = 0;
    d1   = (sp == 0);
    cntr = pos[sp];
    if (sp == MC - 1) begin
      sp = 0;
      if (cmode == 0) pos[4:0] = pos[4:0] + 5'd1;
    end else begin
      sp++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Issue req one clock before a d1 so the first compare shows start_pos.
  task automatic req_aligned(input logic [AB-1:0] a, input logic lw,
                             input logic [4:0] start_pos, input int mode,
                             output int first_d1);
    while (sp != MC - 1) idle(1);
    cmode = mode;
    pos = '0;
    pos[4:0] = (mode == 0) ? start_pos - 5'd1 : start_pos;
    tick(1'b1, 1'b1, a, lw, 1'b0);
    first_d1 = cyc + 1;
  endtask

  // Idle until done or err is seen, bounded by a cycle budget.
  task automatic wait_end(input string name, input int budget);
    int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt; n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < budget) begin
      idle(1);
      n++;
    end
    if (n >= budget) check({name, "_timeout"}, n, -1);
  endtask

  initial begin
    int dstart, fcyc, dbase;
    bit rs, rq, fd;
    logic [AB-1:0] ra;
    logic rl;

    // 1: reset held with req asserted, then idle with req low
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_outputs", int'({busy, gate, done, err}), 0);
    idle(5);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // 2: match on first compare
    gate_rise = -1; done_cnt = 0; err_cnt = 0;
    req_aligned(5'b01101, 1'b0, 5'b01101, 1, dstart);
    wait_end("t2", 200);
    check("t2_gate_rise", gate_rise, dstart + 18);
    check("t2_gate_len", gate_len, 18);
    check("t2_done_cnt", done_cnt, 1);
    idle(1);
    @(negedge clk);
    check("t2_busy_after", int'(busy), 0);

    // 3: counter advancing 3,4,5,6 with addr 6
    gate_rise = -1; done_cnt = 0; err_cnt = 0;
    req_aligned(5'd6, 1'b0, 5'd3, 0, dstart);
    wait_end("t3", 300);
    check("t3_gate_rise", gate_rise, dstart + 4 * 18);
    check("t3_gate_len", gate_len, 18);
    check("t3_err_cnt", err_cnt, 0);

    // 4: long word
    gate_rise = -1; done_cnt = 0; err_cnt = 0;
    req_aligned(5'd0, 1'b1, 5'd0, 1, dstart);
    wait_end("t4", 300);
    check("t4_gate_rise", gate_rise, dstart + 18);
    check("t4_gate_len", gate_len, 36);
    idle(3);
    check("t4_done_cnt", done_cnt, 1);

    // 5: timeout with a stuck-at-zero counter
    gate_rise = -1; done_cnt = 0; err_cnt = 0;
    req_aligned(5'd1, 1'b0, 5'd0, 1, dstart);
    wait_end("t5", 900);
    check("t5_err_rise", err_rise, dstart + 720);
    check("t5_err_cnt", err_cnt, 1);
    check("t5_gate_rise", gate_rise, -1);
    check("t5_done_cnt", done_cnt, 0);
    @(negedge clk);
    check("t5_busy", int'(busy), 0);

    // 6a: reset mid-transfer
    done_cnt = 0;
    req_aligned(5'd5, 1'b0, 5'd5, 1, dstart);
    fcyc = 0;
    while (gate_prev !== 1'b1 && fcyc < 60) begin
      idle(1);
      fcyc++;
    end
    idle(3);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    check("t6_gate_drop", int'(gate), 0);
    dbase = done_cnt;
    idle(40);
    check("t6_no_done", done_cnt, dbase);

    // 6b: off-phase d1 during compare
    gate_rise = -1; done_cnt = 0;
    req_aligned(5'd9, 1'b0, 5'd9, 1, dstart);
    idle(7);
    tick(1'b1, 1'b0, '0, 1'b0, 1'b1);
    fcyc = cyc;
    wait_end("t6b", 200);
    check("t6b_gate_rise", gate_rise, fcyc + 18);
    check("t6b_done_cnt", done_cnt, 1);

    // randomized traffic against the model
    cmode = 0;
    pos[17:5] = 13'($urandom);
    for (int k = 0; k < 5000; k++) begin
      rs = ($urandom_range(499) == 0);
      rq = ($urandom_range(7) == 0);
      fd = ($urandom_range(299) == 0);
      ra = AB'($urandom);
      rl = 1'($urandom_range(1));
      if ($urandom_range(399) == 0) begin
        cmode = int'($urandom_range(1));
        pos[4:0] = 5'($urandom);
      end
      tick(!rs, rq, ra, rl, fd);
    end
    idle(2);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coincidence_unit.md
Name: coincidence_unit

Overview:
- Serial address-coincidence stage directly downstream of the memory-tank counter.
- Each minor cycle, compares the counter's serial output against the word address latched from the order/address path.
- On a match, opens a transfer gate over the next minor cycle (two for a long word), so the tank's word can be read or written.
- A bounded search raises an error if no match ever occurs, e.g. a stuck counter or a missing reset.

Parameters:
- MINOR_CYCLE, 18: digit times (clocks) per minor cycle.
- ADDR_BITS, 5: width of the word position compared, taken from counter bits 0..ADDR_BITS-1.
- TIMEOUT, 40: minor cycles allowed to search before error; must exceed 2**ADDR_BITS.

Ports:
- clk  in  1  system clock, one digit time per cycle
- reset_neg  in  1  synchronous active-low reset
- cntr  in  1  serial counter stream, LSB first, bit k valid at digit index k
- d1  in  1  digit pulse marking digit index 0 of every minor cycle
- req  in  1  request a transfer; sampled only in IDLE
- addr  in  ADDR_BITS  word position; latched when req is accepted
- long_word  in  1  latched with addr; 1 = gate spans two minor cycles
- busy  out  1  high from accept until return to IDLE
- gate  out  1  transfer window to the tank read/write gates
- done  out  1  one-clock pulse at end of a successful transfer
- err  out  1  one-clock pulse on timeout

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low on reset_neg; all state updates on the rising edge of clk.
- Reset values: busy=0, gate=0, done=0, err=0, state=IDLE, digit index=0, search count=0, addr_q=0, long_q=0, mismatch=0.
- Reset mid-operation: aborts immediately. A gate in progress drops on the next edge, and no done or err pulse is issued.
- Digit index: a 0..MINOR_CYCLE-1 counter.
  - Forced to 0 on the clock when d1=1.
  - Otherwise increments and wraps at MINOR_CYCLE-1.
  - A d1 arriving off-phase resynchronises it; no error is raised.
- State IDLE:
  - If req=1, latch addr into addr_q and long_word into long_q, set busy=1 on the next clock, and go to ALIGN.
  - req is ignored while not in IDLE.
- State ALIGN: wait for d1=1.
  - On that clock go to COMPARE, clear mismatch, and clear the search count.
  - The compare of bit 0 happens on this same d1 clock.
- State COMPARE: at digit indices 0..ADDR_BITS-1, mismatch |= cntr XOR addr_q[index]. Other digit indices are ignored.
  - At digit index MINOR_CYCLE-1, when mismatch (including the current bit) is 0, go to TRANSFER with gate=1 from the next clock, which is digit index 0 of the following minor cycle.
  - Otherwise, clear mismatch and increment the search count. When the count reaches TIMEOUT, pulse err for one clock and go to IDLE (busy=0). Otherwise stay in COMPARE.
- State TRANSFER: gate=1 for exactly MINOR_CYCLE clocks, or 2*MINOR_CYCLE when long_q=1.
  - On the last gated clock, go to DONE.
  - The window is fixed length: d1 resyncs during TRANSFER do not shorten or extend it.
- State DONE: gate=0, done=1 for one clock, busy=0 from the next clock, then IDLE.
  - A req on that IDLE clock is accepted, so back-to-back requests work.
- Latency: a matching address gives gate rising exactly one minor cycle after the d1 that began the matching compare. The best case from req is 1 clock to ALIGN plus the wait for d1 plus MINOR_CYCLE.
- Simultaneity: done and err are never asserted together, and gate never overlaps err.

Decomposition:
- Shared control-section package (coincidence_pkg): state encoding (IDLE, ALIGN, COMPARE, TRANSFER, DONE) and the default MINOR_CYCLE constant, also used by the counter and starter logic.
- One natural sub-module, digit_counter: the d1-synchronised 0..MINOR_CYCLE-1 index generator. It is reusable by other serial stages in the control section.

Test Plan:
1. Reset and idle behaviour: hold reset_neg=0 for 3 clocks while driving req=1 -> all outputs 0; after release with req=0, busy stays 0.
2. Match on first compare: addr=5'b01101, long_word=0, cntr serially presents 01101 (LSB first) in the first minor cycle after d1 -> gate high for exactly 18 clocks starting at the next d1 clock, done pulses once, busy low one clock later.
3. Match after counter advance: the counter stream shows positions 3,4,5,6 in successive minor cycles, addr=6 -> gate opens only after the fourth compare cycle, and err=0.
4. Long word: addr=0, long_word=1, match on the first compare -> gate high for 36 consecutive clocks, then a single done pulse.
5. Timeout: cntr held at 0 and addr=1 -> after 40 minor cycles err pulses for 1 clock, gate never rises, done=0, busy=0.
6. Abort and resync: drop reset_neg mid-TRANSFER -> gate=0 on the next clock, no done. Then inject an off-phase d1 during COMPARE -> the digit index restarts at 0 and the compare still matches correctly.
